// File: rtl/mdio_read_phy.sv
// MDIO (clause 22) read master: free-running MDC divider plus a frame FSM that
// shifts out preamble/ST/OP/addresses and captures TA and 16 data bits.
module mdio_read_phy #(
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_divider,
    input  logic        i_rd_en,
    input  logic [4:0]  i_phy_ad,
    input  logic [4:0]  i_phyreg_ad,
    output logic [15:0] o_rd_data,
    output logic        o_read_phy_Dn,
    output logic        o_rd_err,
    output logic        o_busy,
    output logic        o_mdc,
    inout  logic        b_mdio
);

    localparam logic [5:0] PRE_BITS = 6'(PRE_LEN);
    localparam logic [3:0] ST_OP    = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_STOP, S_ADDR, S_TA, S_DATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [13:0] tx_q, tx_d;
    logic [15:0] shift_q, shift_d;
    logic        err_q, err_d;
    logic        oe_q, oe_d;
    logic        do_q, do_d;
    logic [15:0] rd_data_d;
    logic        rd_err_d, dn_d, busy_d;

    logic [6:0]  div_cnt_q;
    logic [6:0]  half;
    logic        mdc_edge, mdc_fall, mdc_rise, mdio_in;

    assign half     = (i_divider == '0) ? 7'd1 : i_divider;
    assign mdc_edge = (div_cnt_q >= half - 7'd1);
    assign mdc_fall = mdc_edge & o_mdc;
    assign mdc_rise = mdc_edge & ~o_mdc;

    assign b_mdio  = oe_q ? do_q : 1'bz;
    assign mdio_in = b_mdio;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q <= '0;
            o_mdc     <= 1'b0;
        end else if (mdc_edge) begin
            div_cnt_q <= '0;
            o_mdc     <= ~o_mdc;
        end else begin
            div_cnt_q <= div_cnt_q + 7'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        err_d     = err_q;
        oe_d      = oe_q;
        do_d      = do_q;
        rd_data_d = o_rd_data;
        rd_err_d  = o_rd_err;
        busy_d    = o_busy;
        dn_d      = 1'b0;
        unique case (state_q)
            S_IDLE: if (i_rd_en) begin
                tx_d      = {ST_OP, i_phy_ad, i_phyreg_ad};
                err_d     = 1'b0;
                busy_d    = 1'b1;
                state_d   = S_PRE;
                bit_cnt_d = '0;
                // An accept coinciding with an MDC fall starts the preamble at once.
                if (mdc_fall) begin
                    oe_d      = 1'b1;
                    do_d      = 1'b1;
                    bit_cnt_d = 6'd1;
                end
            end
            S_PRE: if (mdc_fall) begin
                oe_d = 1'b1;
                if (bit_cnt_q < PRE_BITS) begin
                    do_d      = 1'b1;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else begin
                    do_d      = tx_q[13];
                    tx_d      = {tx_q[12:0], 1'b0};
                    bit_cnt_d = 6'd1;
                    state_d   = S_STOP;
                end
            end
            S_STOP: if (mdc_fall) begin
                do_d      = tx_q[13];
                tx_d      = {tx_q[12:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd4) begin
                    bit_cnt_d = 6'd1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: if (mdc_fall) begin
                if (bit_cnt_q == 6'd10) begin
                    oe_d      = 1'b0;
                    do_d      = 1'b0;
                    bit_cnt_d = 6'd1;
                    state_d   = S_TA;
                end else begin
                    do_d      = tx_q[13];
                    tx_d      = {tx_q[12:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            S_TA: if (mdc_rise) begin
                if (bit_cnt_q == 6'd2 && mdio_in) err_d = 1'b1;
            end else if (mdc_fall) begin
                if (bit_cnt_q == 6'd2) begin
                    bit_cnt_d = 6'd1;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = 6'd2;
                end
            end
            S_DATA: if (mdc_rise) begin
                shift_d = {shift_q[14:0], mdio_in};
                if (bit_cnt_q == 6'd16) state_d = S_DONE;
            end else if (mdc_fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
            // DONE spans one MDC period from the last data sample to the next rise.
            S_DONE: if (mdc_rise) begin
                dn_d      = 1'b1;
                rd_data_d = shift_q;
                rd_err_d  = err_q;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            tx_q          <= '0;
            shift_q       <= '0;
            err_q         <= 1'b0;
            oe_q          <= 1'b0;
            do_q          <= 1'b0;
            o_rd_data     <= '0;
            o_rd_err      <= 1'b0;
            o_busy        <= 1'b0;
            o_read_phy_Dn <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_q          <= tx_d;
            shift_q       <= shift_d;
            err_q         <= err_d;
            oe_q          <= oe_d;
            do_q          <= do_d;
            o_rd_data     <= rd_data_d;
            o_rd_err      <= rd_err_d;
            o_busy        <= busy_d;
            o_read_phy_Dn <= dn_d;
        end
    end

endmodule
